// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that time-multiplexes one 4-bit carry-lookahead adder,
// processing one nibble per cycle LSB first behind valid/ready handshakes.

module carry_lookahead_adder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p, g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [3:0]        cla_sum;
    logic              cla_cout;
    logic              last;

    carry_lookahead_adder_4b u_cla (
        .a    (a_q[4*idx +: 4]),
        .b    (b_q[4*idx +: 4]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    assign last = (idx == IW'(N - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    carry_q <= cin;
                    idx     <= '0;
                end
                RUN: begin
                    sum[4*idx +: 4] <= cla_sum;
                    carry_q         <= cla_cout;
                    idx             <= idx + IW'(1);
                    // Final nibble: its sum MSB is the result MSB, so overflow is known here.
                    if (last) begin
                        cout     <= cla_cout;
                        overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_sum[3] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
